// File: rtl/alu_pkg.sv
// Shared definitions for the sequenced ALU: datapath width, opcodes, FSM encoding.
package alu_pkg;
   localparam int WIDTH = 32;

   localparam logic [3:0] OP_AND = 4'd0;
   localparam logic [3:0] OP_OR  = 4'd1;
   localparam logic [3:0] OP_XOR = 4'd2;
   localparam logic [3:0] OP_NOT = 4'd3;
   localparam logic [3:0] OP_ADD = 4'd4;
   localparam logic [3:0] OP_SUB = 4'd5;
   localparam logic [3:0] OP_SLL = 4'd6;
   localparam logic [3:0] OP_SRL = 4'd7;
   localparam logic [3:0] OP_SRA = 4'd8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;
endpackage

// File: rtl/not32.sv
// Fixed-width 32-bit inverter shared by the SUB and NOT paths.
module not32 (
   input  logic [31:0] d,
   output logic [31:0] q
);
   assign q = ~d;
endmodule

// File: rtl/alu_seq.sv
// Sequenced 32-bit ALU: one-cycle logic/add/sub, bit-serial shifts, result held
// until the writeback stage takes it.
module alu_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_zero,
   output logic             out_carry,
   output logic             out_ovf,
   output logic             out_illegal,
   output logic             busy
);
   import alu_pkg::*;

   state_t           state, state_n;
   logic             ready_q;
   logic [3:0]       op_q;
   logic [4:0]       cnt_q;
   logic [31:0]      sh_q, sh_next;
   logic             sh_out;
   logic [31:0]      result_q;
   logic             zero_q, carry_q, ovf_q, illegal_q;

   logic             accept, is_shift, shift_multi;
   logic [31:0]      not_in, not_q, addend;
   logic [32:0]      sum;
   logic [31:0]      res_c;
   logic             carry_c, ovf_c, ill_c;

   assign accept      = in_valid && ready_q;
   assign is_shift    = (in_op == OP_SLL) || (in_op == OP_SRL) || (in_op == OP_SRA);
   assign shift_multi = is_shift && (in_b[4:0] != 5'd0);

   // NOT reuses the b-path inverter by steering a onto its input
   assign not_in = (in_op == OP_NOT) ? in_a : in_b;
   not32 u_not (.d(not_in), .q(not_q));

   assign addend = (in_op == OP_SUB) ? not_q : in_b;
   assign sum    = {1'b0, in_a} + {1'b0, addend} + {32'd0, (in_op == OP_SUB)};

   always_comb begin
      res_c   = '0;
      carry_c = 1'b0;
      ovf_c   = 1'b0;
      ill_c   = 1'b0;
      case (in_op)
         OP_AND: res_c = in_a & in_b;
         OP_OR:  res_c = in_a | in_b;
         OP_XOR: res_c = in_a ^ in_b;
         OP_NOT: res_c = not_q;
         OP_ADD, OP_SUB: begin
            res_c   = sum[31:0];
            carry_c = sum[32];
            ovf_c   = (in_a[31] == addend[31]) && (sum[31] != in_a[31]);
         end
         OP_SLL, OP_SRL, OP_SRA: res_c = in_a;
         default: ill_c = 1'b1;
      endcase
   end

   always_comb begin
      sh_next = sh_q;
      sh_out  = 1'b0;
      case (op_q)
         OP_SLL:  {sh_out, sh_next} = {sh_q, 1'b0};
         OP_SRL:  {sh_next, sh_out} = {1'b0, sh_q};
         OP_SRA:  {sh_next, sh_out} = {sh_q[31], sh_q};
         default: ;
      endcase
   end

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         ready_q <= 1'b0;
      end else begin
         state   <= state_n;
         ready_q <= (state_n == ST_IDLE);
      end
   end

   // FSM: next state
   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE:  if (accept) state_n = shift_multi ? ST_SHIFT : ST_DONE;
         ST_SHIFT: if (cnt_q == 5'd1) state_n = ST_DONE;
         ST_DONE:  if (out_ready) state_n = ST_IDLE;
         default:  state_n = ST_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      in_ready  = ready_q;
      out_valid = (state == ST_DONE);
      busy      = (state != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q      <= '0;
         cnt_q     <= '0;
         sh_q      <= '0;
         result_q  <= '0;
         zero_q    <= 1'b0;
         carry_q   <= 1'b0;
         ovf_q     <= 1'b0;
         illegal_q <= 1'b0;
      end else if (accept) begin
         op_q <= in_op;
         if (shift_multi) begin
            sh_q      <= in_a;
            cnt_q     <= in_b[4:0];
            carry_q   <= 1'b0;
            ovf_q     <= 1'b0;
            illegal_q <= 1'b0;
         end else begin
            result_q  <= res_c;
            zero_q    <= (res_c == 32'd0);
            carry_q   <= carry_c;
            ovf_q     <= ovf_c;
            illegal_q <= ill_c;
         end
      end else if (state == ST_SHIFT) begin
         sh_q    <= sh_next;
         carry_q <= sh_out;
         cnt_q   <= cnt_q - 5'd1;
         if (cnt_q == 5'd1) begin
            result_q <= sh_next;
            zero_q   <= (sh_next == 32'd0);
         end
      end
   end

   assign out_result  = result_q;
   assign out_zero    = zero_q;
   assign out_carry   = carry_q;
   assign out_ovf     = ovf_q;
   assign out_illegal = illegal_q;
endmodule
